// File: rtl/noisy_channel.sv
// Purpose: channel model; adds button-selected LFSR noise to each sample and saturates it.
// Latency: one clk_10 cycle from channel_input to channel_output; KEY changes reach the output two edges later.
// Backpressure: none; a new sample is accepted and produced on every rising edge.
module noisy_channel #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned LOW_SHIFT  = 10,
  parameter int unsigned MED_SHIFT  = 7,
  parameter int unsigned HIGH_SHIFT = 4
) (
  input  logic        clk_10,
  input  logic        reset,
  input  logic [15:0] channel_input,
  output logic [15:0] channel_output,
  input  logic [2:0]  KEY
);

  // An all-zero seed would lock the LFSR up, so it is replaced with 1.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_LOW  = 2'd1,
    MODE_MED  = 2'd2,
    MODE_HIGH = 2'd3
  } mode_t;

  logic [2:0]         key_s1;
  logic [2:0]         key_s2;
  mode_t              mode;
  logic [15:0]        lfsr;
  logic               lfsr_fb;
  logic signed [15:0] noise;
  logic signed [16:0] sum;
  logic [15:0]        sat;

  // Two-flop synchronizer for the asynchronous push-buttons; idle (released) during reset.
  always_ff @(posedge clk_10 or negedge reset) begin
    if (!reset) begin
      key_s1 <= 3'b111;
      key_s2 <= 3'b111;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
    end
  end

  // Buttons are active-low; the highest-numbered pressed button wins.
  always_comb begin
    mode = MODE_NONE;
    if (!key_s2[2])      mode = MODE_HIGH;
    else if (!key_s2[1]) mode = MODE_MED;
    else if (!key_s2[0]) mode = MODE_LOW;
  end

  // Fibonacci taps 16,14,13,11 give a maximal-length sequence that never hits zero.
  always_comb begin
    lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  end

  // LFSR runs every cycle regardless of mode so the noise stream stays deterministic.
  always_ff @(posedge clk_10 or negedge reset) begin
    if (!reset) lfsr <= SEED;
    else        lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // Noise amplitude is the signed LFSR word scaled down by an arithmetic shift (floor).
  always_comb begin
    noise = 16'sd0;
    case (mode)
      MODE_LOW:  noise = $signed(lfsr) >>> LOW_SHIFT;
      MODE_MED:  noise = $signed(lfsr) >>> MED_SHIFT;
      MODE_HIGH: noise = $signed(lfsr) >>> HIGH_SHIFT;
      default:   noise = 16'sd0;
    endcase
  end

  // 17-bit sum cannot overflow; clamp when the top two bits disagree.
  always_comb begin
    sum = $signed({channel_input[15], channel_input}) + $signed({noise[15], noise});
    sat = sum[15:0];
    if (sum[16] != sum[15]) sat = sum[16] ? 16'h8000 : 16'h7FFF;
  end

  // Registered output gives exactly one cycle of latency.
  always_ff @(posedge clk_10 or negedge reset) begin
    if (!reset) channel_output <= 16'h0000;
    else        channel_output <= sat;
  end

endmodule

// File: tb/tb_noisy_channel.sv
// Scoreboard bench for noisy_channel: stimulus pushes hand-computed outputs, monitor compares after each edge.
// LFSR words used after release: ACE1, 59C3, B387, 670F, CE1E (edges 1..5).
// Expected noise at edges 3..5: HIGH -1224/+1648/-799, MED -153/+206/-100, LOW -20/+25/-13.
module tb_noisy_channel;

  logic        clk_10;
  logic        reset;
  logic [15:0] channel_input;
  logic [15:0] channel_output;
  logic [2:0]  KEY;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int total = 0;
  int bad   = 0;
  bit stim_done = 0;

  noisy_channel dut (
    .clk_10         (clk_10),
    .reset          (reset),
    .channel_input  (channel_input),
    .channel_output (channel_output),
    .KEY            (KEY)
  );

  initial clk_10 = 1'b0;
  always #5 clk_10 = ~clk_10;

  // Called at a falling edge: drive the sample, record what the next rising edge must produce.
  task automatic step(input logic [15:0] din, input logic [15:0] exp, input string nm);
    sb_entry_t e;
    channel_input = din;
    e.exp  = exp;
    e.name = nm;
    sb_q.push_back(e);
    @(negedge clk_10);
  endtask

  // Hold reset for a few cycles with the given buttons, toggling the input; output must stay 0.
  task automatic do_reset(input logic [2:0] keys);
    reset = 1'b0;
    KEY   = keys;
    step(16'h1234, 16'h0000, "rst_hold0");
    step(16'hFFFF, 16'h0000, "rst_hold1");
    step(16'h8000, 16'h0000, "rst_hold2");
    reset = 1'b1;
  endtask

  // Monitor: after every rising edge, pop one expectation if any and compare.
  initial begin
    sb_entry_t e;
    forever begin
      @(posedge clk_10);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        total++;
        if (channel_output !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h (%0d) expected %h (%0d)", e.name,
                   channel_output, $signed(channel_output), e.exp, $signed(e.exp));
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    KEY           = 3'b111;
    channel_input = 16'h0000;
    @(negedge clk_10);

    // Reset state observed directly while reset is held.
    total++;
    if (channel_output !== 16'h0000) begin
      bad++;
      $display("FAIL reset_value: got %h expected 0000", channel_output);
    end

    // Pass-through, no buttons pressed.
    do_reset(3'b111);
    step(16'd43224, 16'd43224, "pass0");
    step(16'd34232, 16'd34232, "pass1");
    step(16'd15423, 16'd15423, "pass2");
    step(16'h0000,  16'h0000,  "pass3");

    // HIGH noise, positive full-scale input.
    do_reset(3'b011);
    step(16'h7FFF, 16'h7FFF,       "hi_pos_e1");
    step(16'h7FFF, 16'h7FFF,       "hi_pos_e2");
    step(16'h7FFF, 16'd31543,      "hi_pos_e3");
    step(16'h7FFF, 16'h7FFF,       "hi_pos_e4_sat");
    step(16'h7FFF, 16'd31968,      "hi_pos_e5");

    // HIGH noise, negative full-scale input.
    do_reset(3'b011);
    step(16'h8000, 16'h8000,       "hi_neg_e1");
    step(16'h8000, 16'h8000,       "hi_neg_e2");
    step(16'h8000, 16'h8000,       "hi_neg_e3_sat");
    step(16'h8000, 16'h8670,       "hi_neg_e4");
    step(16'h8000, 16'h8000,       "hi_neg_e5_sat");

    // LOW noise.
    do_reset(3'b110);
    step(16'd1000, 16'd1000,       "low_e1");
    step(16'd1000, 16'd1000,       "low_e2");
    step(16'd1000, 16'd980,        "low_e3");
    step(16'd1000, 16'd1025,       "low_e4");
    step(16'd1000, 16'd987,        "low_e5");

    // MED noise.
    do_reset(3'b101);
    step(16'd1000, 16'd1000,       "med_e1");
    step(16'd1000, 16'd1000,       "med_e2");
    step(16'd1000, 16'd847,        "med_e3");
    step(16'd1000, 16'd1206,       "med_e4");
    step(16'd1000, 16'd900,        "med_e5");

    // KEY[2] and KEY[0] pressed: HIGH must win.
    do_reset(3'b010);
    step(16'd0, 16'h0000,          "prio_e1");
    step(16'd0, 16'h0000,          "prio_e2");
    step(16'd0, 16'hFB38,          "prio_e3");
    step(16'd0, 16'h0670,          "prio_e4");
    step(16'd0, 16'hFCE1,          "prio_e5");

    // Asynchronous reset between edges drops the output at once.
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (channel_output !== 16'h0000) begin
      bad++;
      $display("FAIL async_reset: got %h expected 0000", channel_output);
    end
    @(negedge clk_10);

    // After release the noise sequence restarts from the seed word.
    do_reset(3'b010);
    step(16'd0, 16'h0000,          "restart_e1");
    step(16'd0, 16'h0000,          "restart_e2");
    step(16'd0, 16'hFB38,          "restart_e3");
    step(16'd0, 16'h0670,          "restart_e4");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk_10);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    stim_done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noisy_channel.md
Name: noisy_channel

Overview:
- Models the transmission channel between encoder and decoder in the digital communication system.
- Every clock cycle it takes one 16-bit signed sample, adds pseudo-random noise whose amplitude is chosen by the board push-buttons, saturates the result, and registers it out.
- With no button pressed it is a one-cycle pass-through delay.

Parameters:
- LFSR_SEED, 16'hACE1, reset value of the noise LFSR; a value of 0 is replaced by 16'h0001.
- LOW_SHIFT, 10, arithmetic right shift applied to the LFSR word in low-noise mode.
- MED_SHIFT, 7, arithmetic right shift applied in medium-noise mode.
- HIGH_SHIFT, 4, arithmetic right shift applied in high-noise mode.

Ports:
- clk_10  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- channel_input  input  16  transmitted sample, two's-complement signed.
- channel_output  output  16  received sample, two's-complement signed, registered.
- KEY  input  3  push-buttons, active-low (0 = pressed), asynchronous to clk_10.

Behaviour:
- Reset (reset = 0, asynchronous):
  - channel_output = 0.
  - LFSR = LFSR_SEED.
  - Both KEY synchronizer stages = 3'b111 (not pressed).
  - Held for as long as reset is low.
- KEY synchronizer:
  - Two flops per bit, s1 <= KEY and s2 <= s1.
  - Mode is decoded combinationally from s2.
  - A KEY change before edge k first affects the output computed at edge k+2.
- Mode decode (active-low, priority KEY[2] > KEY[1] > KEY[0]):
  - s2[2] = 0: HIGH.
  - else s2[1] = 0: MED.
  - else s2[0] = 0: LOW.
  - else: NONE.
- LFSR:
  - 16-bit Fibonacci, free-running every clock (in every mode).
  - fb = l[15]^l[13]^l[12]^l[10]; next l = {l[14:0], fb}.
  - Never reaches all-zero state.
- Noise, computed from the current (pre-advance) LFSR word L as signed:
  - NONE: 0.
  - LOW: L >>> LOW_SHIFT.
  - MED: L >>> MED_SHIFT.
  - HIGH: L >>> HIGH_SHIFT.
  - Arithmetic shift (floor), sign-extended to 16 bits.
- Sum:
  - 17-bit signed sum = channel_input + noise.
  - Saturate to [-32768, 32767]; no wrap-around.
- Output timing:
  - channel_output <= saturated sum on each rising edge, giving one cycle of latency.
  - The LFSR advances on the same edge.
- Mode changes take effect cleanly with no output glitch; a mid-stream reset returns all state to reset values immediately.
- Inputs above 32767 unsigned are treated as negative (e.g. 43224 = -22312).

Test Plan:
- Reset: hold reset = 0, toggle channel_input -> channel_output stays 16'h0000. Release reset -> the first edge uses an LFSR word of 16'hACE1, and the LFSR becomes 16'h59C3 after that edge.
- Pass-through: KEY = 3'b111, input sequence 43224, 34232, 15423 -> output equals the same sequence, delayed exactly one clock.
- High noise + positive saturation check:
  - Setup: KEY = 3'b011 held through reset, channel_input = 32767.
  - Edges 1 and 2 after release -> output 32767 (keys not yet synchronized).
  - Edge 3 uses LFSR 16'hB387, noise -1224 -> output 31543.
- Negative saturation: same setup with channel_input = 16'h8000 -> edge 3 output 16'h8000 (-32768 - 1224 clamps); output never goes positive.
- Low/Med noise on seed word:
  - Force the mode before the first edge by holding KEY through reset and 2 extra cycles with the LFSR restarted, or compute from the known sequence.
  - Noise on word 16'hACE1 is -21 (LOW) and -167 (MED); input 1000 gives 979 and 833.
- Priority and asynchronous reset:
  - KEY = 3'b010 (KEY[2] and KEY[0] pressed) -> HIGH amplitude is used (|noise| up to 2048).
  - Assert reset mid-stream between clock edges -> output drops to 0 immediately.
  - After release, the noise sequence restarts from 16'hACE1.
